// File: rtl/spi_slave_mc.sv
// SPI slave with runtime mode and bit order, a DEPTH-word TX buffer and RX word capture; SPI_SLV_CNT_EN adds frame/word counters.
// Latency: pin changes act SYNC_STAGES+1 clk100 later; rx_valid_o pulses the cycle after the final sample edge.
// Backpressure: none; TX writes are accepted every cycle and each new RX word overwrites rx_data_o.
module spi_slave_mc #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk100,
    input  logic                     rst,
    input  logic [1:0]               mode_i,
    input  logic                     lsb_first_i,
    input  logic                     tx_we_i,
    input  logic [$clog2(DEPTH)-1:0] tx_addr_i,
    input  logic [DW-1:0]            tx_data_i,
    input  logic                     sclk_i,
    input  logic                     csn_i,
    input  logic                     mosi_i,
    output logic                     miso_o,
    output logic [DW-1:0]            rx_data_o,
    output logic                     rx_valid_o,
    output logic [$clog2(DEPTH)-1:0] rx_idx_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     err_partial_o
`ifdef SPI_SLV_CNT_EN
    ,
    output logic [15:0]              frame_cnt_o,
    output logic [15:0]              word_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DW);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sy, csn_sy, mosi_sy;
    logic                   sclk_d, csn_d;
    logic                   cpol_r, cpha_r, lsb_r;
    logic [BW-1:0]          bit_cnt;
    logic [AW-1:0]          word_idx;
    logic [DW-1:0]          tx_sh, rx_sh;
    logic                   reload_pend;
    logic [DW-1:0]          tx_buf [DEPTH];

    function automatic logic obit(input logic [DW-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DW-1];
    endfunction

    // CSn chain resets low so a frame cut short by reset is not re-entered mid-transfer.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            sclk_sy <= '0;
            csn_sy  <= '0;
            mosi_sy <= '0;
            sclk_d  <= 1'b0;
            csn_d   <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_i};
            csn_sy  <= {csn_sy[SYNC_STAGES-2:0], csn_i};
            mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi_i};
            sclk_d  <= sclk_sy[SYNC_STAGES-1];
            csn_d   <= csn_sy[SYNC_STAGES-1];
        end
    end

    logic sclk_s, csn_s, mosi_s;
    logic sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic lead_ev, trail_ev, samp_ev, shift_ev, last_bit;

    assign sclk_s    = sclk_sy[SYNC_STAGES-1];
    assign csn_s     = csn_sy[SYNC_STAGES-1];
    assign mosi_s    = mosi_sy[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign csn_fall  = ~csn_s & csn_d;
    assign csn_rise  = csn_s & ~csn_d;
    assign lead_ev   = cpol_r ? sclk_fall : sclk_rise;
    assign trail_ev  = cpol_r ? sclk_rise : sclk_fall;
    assign samp_ev   = cpha_r ? trail_ev : lead_ev;
    assign shift_ev  = cpha_r ? lead_ev : trail_ev;
    assign last_bit  = (bit_cnt == BW'(DW - 1));

    // Buffer reads forward a same-cycle write so a load never sees stale data.
    logic [AW-1:0] nxt_idx, rl_idx;
    logic [DW-1:0] ld0_dat, rl_dat, shift_src, tx_shf, rx_nxt;

    assign nxt_idx   = word_idx + AW'(1);
    assign rl_idx    = cpha_r ? word_idx : nxt_idx;
    assign ld0_dat   = (tx_we_i && tx_addr_i == '0) ? tx_data_i : tx_buf[0];
    assign rl_dat    = (tx_we_i && tx_addr_i == rl_idx) ? tx_data_i : tx_buf[rl_idx];
    assign shift_src = reload_pend ? rl_dat : tx_sh;
    assign tx_shf    = lsb_r ? (tx_sh >> 1) : (tx_sh << 1);
    assign rx_nxt    = lsb_r ? {mosi_s, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], mosi_s};

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tx_buf[i] <= '0;
        end else if (tx_we_i) begin
            tx_buf[tx_addr_i] <= tx_data_i;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            lsb_r         <= 1'b0;
            bit_cnt       <= '0;
            word_idx      <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            reload_pend   <= 1'b0;
            miso_o        <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_idx_o      <= '0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            err_partial_o <= 1'b0;
        end else begin
            rx_valid_o   <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state         <= ACTIVE;
                        cpol_r        <= mode_i[1];
                        cpha_r        <= mode_i[0];
                        lsb_r         <= lsb_first_i;
                        bit_cnt       <= '0;
                        word_idx      <= '0;
                        err_partial_o <= 1'b0;
                        busy_o        <= 1'b1;
                        reload_pend   <= 1'b0;
                        tx_sh         <= ld0_dat;
                        miso_o        <= mode_i[0] ? 1'b0 : obit(ld0_dat, lsb_first_i);
                    end
                end
                ACTIVE: begin
                    if (samp_ev) begin
                        rx_sh <= rx_nxt;
                        if (last_bit) begin
                            bit_cnt    <= '0;
                            rx_data_o  <= rx_nxt;
                            rx_idx_o   <= word_idx;
                            rx_valid_o <= 1'b1;
                            word_idx   <= nxt_idx;
                            if (!cpha_r) begin
                                tx_sh  <= rl_dat;
                                miso_o <= obit(rl_dat, lsb_r);
                            end else begin
                                reload_pend <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    // At bit_cnt 0 the word's first bit is already presented (CPHA=0) or is presented now (CPHA=1).
                    if (shift_ev) begin
                        if (bit_cnt != '0) begin
                            tx_sh  <= tx_shf;
                            miso_o <= obit(tx_shf, lsb_r);
                        end else if (cpha_r) begin
                            tx_sh       <= shift_src;
                            miso_o      <= obit(shift_src, lsb_r);
                            reload_pend <= 1'b0;
                        end
                    end
                    if (csn_rise) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        frame_done_o <= 1'b1;
                        miso_o       <= 1'b0;
                        reload_pend  <= 1'b0;
                        if (!(samp_ev && last_bit) && bit_cnt != '0)
                            err_partial_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLV_CNT_EN
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            frame_cnt_o <= '0;
            word_cnt_o  <= '0;
        end else begin
            if (frame_done_o) frame_cnt_o <= frame_cnt_o + 16'd1;
            if (rx_valid_o)   word_cnt_o  <= word_cnt_o + 16'd1;
        end
    end
`endif

endmodule
